// File: rtl/fb_scheduler_if.sv
// Renderer write channel and single-port frame-buffer RAM bus shared by fb_scheduler.
`timescale 1ns/1ps
interface fb_scheduler_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              wr_valid_in;
  logic [ADDR_W-1:0] wr_addr_in;
  logic [DATA_W-1:0] wr_data_in;
  logic              wr_ready_out;
  logic [ADDR_W:0]   mem_addr_out;
  logic              mem_we_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic [DATA_W-1:0] mem_rdata_in;

  // Environment side: renderer plus RAM
  modport master (
    output wr_valid_in, wr_addr_in, wr_data_in, mem_rdata_in,
    input  wr_ready_out, mem_addr_out, mem_we_out, mem_wdata_out
  );

  modport slave (
    input  wr_valid_in, wr_addr_in, wr_data_in, mem_rdata_in,
    output wr_ready_out, mem_addr_out, mem_we_out, mem_wdata_out
  );
endinterface

// File: rtl/fb_scheduler.sv
// Frame-buffer scheduler: scanout-priority RAM arbitration plus render/swap FSM.
// Define FB_DOUBLE_BUFFER_EN for front/back banks; undefined uses a single bank 0.
`timescale 1ns/1ps
module fb_scheduler #(
  parameter int WIDTH  = 300,
  parameter int HEIGHT = 300,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              clk_pixel_in,
  input  logic              rst_n_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              nf_in,
  input  logic              render_done_in,
  fb_scheduler_if.slave     bus,
  output logic              render_start_out,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid_out,
  output logic              front_bank_out,
  output logic              late_out
);
  localparam logic [ADDR_W:0] PIX_COUNT = (ADDR_W+1)'(WIDTH * HEIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RENDER = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              front_q, front_d;
  logic              start_q, start_d;
  logic              late_q, late_d;
  logic [ADDR_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              scan_p1_q, scan_p1_d;
  logic              scan_p2_q, scan_p2_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic              pix_valid_q, pix_valid_d;

  logic scan_active_s;
  logic wr_ready_s;
  logic wr_fire_s;
  logic wr_in_range_s;
  logic rd_bank_s;
  logic wr_bank_s;

  assign scan_active_s = (hcount_in < 11'(WIDTH)) && (vcount_in < 10'(HEIGHT));
  assign wr_ready_s    = (state_q == RENDER) && !scan_active_s;
  assign wr_fire_s     = bus.wr_valid_in && wr_ready_s;
  assign wr_in_range_s = ({1'b0, bus.wr_addr_in} < PIX_COUNT);

`ifdef FB_DOUBLE_BUFFER_EN
  assign rd_bank_s = front_q;
  assign wr_bank_s = ~front_q;
`else
  assign rd_bank_s = 1'b0;
  assign wr_bank_s = 1'b0;
`endif

  // Render sequencing; a frame boundary that finds the renderer busy repeats the old front
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    start_d = 1'b0;
    late_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (nf_in) begin
          state_d = RENDER;
          start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RENDER: begin
        if (render_done_in) begin
          state_d = DONE;
          late_d  = nf_in;
        end else if (nf_in) begin
          late_d = 1'b1;
        end else begin
          state_d = RENDER;
        end
      end
      DONE: begin
        if (nf_in) begin
          state_d = RENDER;
          start_d = 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
          front_d = ~front_q;
`endif
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM arbitration (scanout always wins) and the 3-stage pixel return path
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    if (nf_in) begin
      scan_cnt_d = {ADDR_W{1'b0}};
    end else if (scan_active_s) begin
      scan_cnt_d = scan_cnt_q + ADDR_W'(1);
    end else begin
      scan_cnt_d = scan_cnt_q;
    end
    if (scan_active_s) begin
      mem_addr_d = {rd_bank_s, scan_cnt_q};
    end else if (wr_fire_s && wr_in_range_s) begin
      mem_addr_d  = {wr_bank_s, bus.wr_addr_in};
      mem_we_d    = 1'b1;
      mem_wdata_d = bus.wr_data_in;
    end else begin
      mem_we_d = 1'b0;
    end
    scan_p1_d   = scan_active_s;
    scan_p2_d   = scan_p1_q;
    pix_valid_d = scan_p2_q;
    if (scan_p2_q) begin
      pix_d = bus.mem_rdata_in;
    end else begin
      pix_d = {DATA_W{1'b0}};
    end
  end

  // State and output registers; reset discards any in-flight access
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      front_q     <= 1'b0;
      start_q     <= 1'b0;
      late_q      <= 1'b0;
      scan_cnt_q  <= {ADDR_W{1'b0}};
      mem_addr_q  <= {(ADDR_W+1){1'b0}};
      mem_we_q    <= 1'b0;
      mem_wdata_q <= {DATA_W{1'b0}};
      scan_p1_q   <= 1'b0;
      scan_p2_q   <= 1'b0;
      pix_q       <= {DATA_W{1'b0}};
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      start_q     <= start_d;
      late_q      <= late_d;
      scan_cnt_q  <= scan_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      scan_p1_q   <= scan_p1_d;
      scan_p2_q   <= scan_p2_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign bus.wr_ready_out  = wr_ready_s;
  assign bus.mem_addr_out  = mem_addr_q;
  assign bus.mem_we_out    = mem_we_q;
  assign bus.mem_wdata_out = mem_wdata_q;
  assign render_start_out  = start_q;
  assign pix_out           = pix_q;
  assign pix_valid_out     = pix_valid_q;
  assign front_bank_out    = front_q;
  assign late_out          = late_q;

endmodule

// File: tb/tb_fb_scheduler.sv
// Directed bench for fb_scheduler: table of per-cycle vectors plus hand-written swap/late/reset sequences.
`timescale 1ns/1ps
module tb_fb_scheduler;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  // Bank base of renderer writes while the front bank is 0
  localparam logic [17:0] WB = DB ? 18'h20000 : 18'h00000;

  logic        clk;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        nf;
  logic        render_done;
  logic        render_start;
  logic [7:0]  pix;
  logic        pix_valid;
  logic        front;
  logic        late;

  int n_chk  = 0;
  int n_fail = 0;

  fb_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_scheduler #(.WIDTH(300), .HEIGHT(300), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_pixel_in     (clk),
    .rst_n_in         (rst_n),
    .hcount_in        (hcount),
    .vcount_in        (vcount),
    .nf_in            (nf),
    .render_done_in   (render_done),
    .bus              (bus),
    .render_start_out (render_start),
    .pix_out          (pix),
    .pix_valid_out    (pix_valid),
    .front_bank_out   (front),
    .late_out         (late)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM model, 1-cycle read latency, both banks
  bit [7:0] ram [0:(1<<18)-1];
  bit       loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      ram[0]          <= 8'd11;
      ram[1]          <= 8'd22;
      ram[2]          <= 8'd33;
      ram[18'h20000]  <= 8'h99;
      loaded          <= 1'b1;
    end
    bus.mem_rdata_in <= ram[bus.mem_addr_out];
    if (bus.mem_we_out) ram[bus.mem_addr_out] <= bus.mem_wdata_out;
  end

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        wv;
    logic [16:0] wa;
    logic [7:0]  wd;
    logic        rd;
    logic        e_ready;
    logic [17:0] e_addr;
    logic        e_we;
    logic [7:0]  e_wd;
    logic [7:0]  e_pix;
    logic        e_pv;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(bus.mem_addr_out), 32'h0);
    chk({tag, "_we"}, 32'(bus.mem_we_out), 32'h0);
    chk({tag, "_wdata"}, 32'(bus.mem_wdata_out), 32'h0);
    chk({tag, "_ready"}, 32'(bus.wr_ready_out), 32'h0);
    chk({tag, "_start"}, 32'(render_start), 32'h0);
    chk({tag, "_pix"}, 32'(pix), 32'h0);
    chk({tag, "_pv"}, 32'(pix_valid), 32'h0);
    chk({tag, "_front"}, 32'(front), 32'h0);
    chk({tag, "_late"}, 32'(late), 32'h0);
  endtask

  initial begin
    //          h        v      wv    wa          wd     rd    rdy   addr          we    wdata  pix    pv
    vt[0] = '{11'd0,   10'd0, 1'b0, 17'd0,     8'h00, 1'b0, 1'b0, 18'd0,        1'b0, 8'h00, 8'd0,  1'b0};
    vt[1] = '{11'd1,   10'd0, 1'b0, 17'd0,     8'h00, 1'b0, 1'b0, 18'd1,        1'b0, 8'h00, 8'd0,  1'b0};
    vt[2] = '{11'd2,   10'd0, 1'b0, 17'd0,     8'h00, 1'b0, 1'b0, 18'd2,        1'b0, 8'h00, 8'd11, 1'b1};
    vt[3] = '{11'd5,   10'd0, 1'b1, 17'd7,     8'hAA, 1'b0, 1'b0, 18'd3,        1'b0, 8'h00, 8'd22, 1'b1};
    vt[4] = '{11'd400, 10'd0, 1'b1, 17'd7,     8'hAA, 1'b0, 1'b1, WB | 18'd7,   1'b1, 8'hAA, 8'd33, 1'b1};
    vt[5] = '{11'd400, 10'd0, 1'b0, 17'd0,     8'h00, 1'b0, 1'b1, WB | 18'd7,   1'b0, 8'hAA, 8'd0,  1'b1};
    vt[6] = '{11'd400, 10'd0, 1'b1, 17'd90000, 8'h55, 1'b0, 1'b1, WB | 18'd7,   1'b0, 8'hAA, 8'd0,  1'b0};
    vt[7] = '{11'd400, 10'd0, 1'b1, 17'd8,     8'h5A, 1'b1, 1'b1, WB | 18'd8,   1'b1, 8'h5A, 8'd0,  1'b0};
    vt[8] = '{11'd400, 10'd0, 1'b1, 17'd9,     8'h66, 1'b0, 1'b0, WB | 18'd8,   1'b0, 8'h5A, 8'd0,  1'b0};

    rst_n = 1'b0;
    hcount = 11'd400;
    vcount = 10'd350;
    nf = 1'b0;
    render_done = 1'b0;
    bus.wr_valid_in = 1'b0;
    bus.wr_addr_in = 17'd0;
    bus.wr_data_in = 8'h00;
    repeat (3) tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(bus.wr_ready_out), 32'h0);
    chk("idle_start", 32'(render_start), 32'h0);

    // First frame boundary leaves IDLE
    nf = 1'b1;
    tick();
    nf = 1'b0;
    chk("first_start", 32'(render_start), 32'h1);
    chk("first_front", 32'(front), 32'h0);
    chk("first_late", 32'(late), 32'h0);
    tick();
    chk("first_start_end", 32'(render_start), 32'h0);
    chk("render_ready", 32'(bus.wr_ready_out), 32'h1);

    for (int i = 0; i < 9; i++) begin
      hcount = vt[i].h;
      vcount = vt[i].v;
      bus.wr_valid_in = vt[i].wv;
      bus.wr_addr_in = vt[i].wa;
      bus.wr_data_in = vt[i].wd;
      render_done = vt[i].rd;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.wr_ready_out), 32'(vt[i].e_ready));
      tick();
      chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr_out), 32'(vt[i].e_addr));
      chk($sformatf("v%0d_we", i), 32'(bus.mem_we_out), 32'(vt[i].e_we));
      chk($sformatf("v%0d_wdata", i), 32'(bus.mem_wdata_out), 32'(vt[i].e_wd));
      chk($sformatf("v%0d_pix", i), 32'(pix), 32'(vt[i].e_pix));
      chk($sformatf("v%0d_pv", i), 32'(pix_valid), 32'(vt[i].e_pv));
    end
    bus.wr_valid_in = 1'b0;
    render_done = 1'b0;
    vcount = 10'd350;

    // DONE + new frame: bank swap and scanout from the new front
    nf = 1'b1;
    tick();
    nf = 1'b0;
    chk("swap_start", 32'(render_start), 32'h1);
    chk("swap_front", 32'(front), 32'(DB));
    chk("swap_late", 32'(late), 32'h0);
    tick();
    chk("swap_ready", 32'(bus.wr_ready_out), 32'h1);
    hcount = 11'd0;
    vcount = 10'd0;
    tick();
    chk("swap_rd_addr", 32'(bus.mem_addr_out), DB ? 32'h20000 : 32'h0);
    hcount = 11'd400;
    vcount = 10'd350;
    tick();
    tick();
    chk("swap_pix", 32'(pix), DB ? 32'h99 : 32'd11);
    chk("swap_pv", 32'(pix_valid), 32'h1);

    // Frame boundary while still rendering
    nf = 1'b1;
    tick();
    nf = 1'b0;
    chk("late_pulse", 32'(late), 32'h1);
    chk("late_start", 32'(render_start), 32'h0);
    chk("late_front", 32'(front), 32'(DB));
    tick();
    chk("late_end", 32'(late), 32'h0);
    chk("late_ready", 32'(bus.wr_ready_out), 32'h1);

    // Done and frame boundary together: late, no swap until the next boundary
    render_done = 1'b1;
    nf = 1'b1;
    tick();
    render_done = 1'b0;
    nf = 1'b0;
    chk("both_late", 32'(late), 32'h1);
    chk("both_start", 32'(render_start), 32'h0);
    chk("both_front", 32'(front), 32'(DB));
    chk("both_ready", 32'(bus.wr_ready_out), 32'h0);
    tick();
    nf = 1'b1;
    tick();
    nf = 1'b0;
    chk("swap2_start", 32'(render_start), 32'h1);
    chk("swap2_front", 32'(front), 32'h0);
    tick();

    // Asynchronous reset in the middle of a write
    hcount = 11'd600;
    bus.wr_valid_in = 1'b1;
    bus.wr_addr_in = 17'd5;
    bus.wr_data_in = 8'h33;
    #1;
    chk("mid_ready", 32'(bus.wr_ready_out), 32'h1);
    tick();
    chk("mid_we", 32'(bus.mem_we_out), 32'h1);
    chk("mid_addr", 32'(bus.mem_addr_out), 32'(WB | 18'd5));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    bus.wr_valid_in = 1'b0;
    hcount = 11'd400;
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus.wr_ready_out), 32'h0);
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    chk("idle_done_start", 32'(render_start), 32'h0);
    chk("idle_done_ready", 32'(bus.wr_ready_out), 32'h0);
    nf = 1'b1;
    tick();
    nf = 1'b0;
    chk("restart_start", 32'(render_start), 32'h1);
    chk("restart_front", 32'(front), 32'h0);
    chk("restart_ready", 32'(bus.wr_ready_out), 32'h1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
